// File: rtl/tlb_refill_ctrl.sv
// Shared I/D TLB refill controller: round-robin miss arbitration,
// single-level page-table walk, TLB write-back and done/fault reporting.
module tlb_refill_ctrl #(
    parameter int ARCH_BITS    = 32,
    parameter int PAGE_BITS    = 12,
    parameter int FILL_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARCH_BITS-1:0] ptbr,
    input  logic                 iMissReq,
    input  logic [ARCH_BITS-1:0] iMissVAddr,
    input  logic                 dMissReq,
    input  logic [ARCH_BITS-1:0] dMissVAddr,
    output logic                 iDone,
    output logic                 dDone,
    output logic                 iFault,
    output logic                 dFault,
    output logic                 memReq,
    output logic [ARCH_BITS-1:0] memAddr,
    input  logic                 memAck,
    input  logic [ARCH_BITS-1:0] memData,
    output logic                 iTlbWriteReq,
    output logic                 dTlbWriteReq,
    output logic [ARCH_BITS-1:0] tlbVAddr,
    output logic [ARCH_BITS-1:0] tlbPAddr,
    input  logic                 iTlbAck,
    input  logic                 dTlbAck,
    output logic                 busy
);

    localparam int CW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [ARCH_BITS-1:0] PAGE_MASK = {{(ARCH_BITS-PAGE_BITS){1'b1}}, {PAGE_BITS{1'b0}}};
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WALK,
        FILL,
        RESP,
        FAULT
    } state_t;

    state_t               state, state_nxt;
    logic                 sel, sel_nxt;
    logic                 last_grant, last_grant_nxt;
    logic [ARCH_BITS-1:0] vaddr, vaddr_nxt;
    logic [ARCH_BITS-1:0] addr, addr_nxt;
    logic [ARCH_BITS-1:0] pte, pte_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;

    logic                 grant_d;
    logic [ARCH_BITS-1:0] req_va;
    logic [ARCH_BITS-1:0] pte_off;
    logic                 tlb_ack;

    // D wins only when I is absent or I was the last one served
    assign grant_d = dMissReq && (!iMissReq || last_grant == SEL_I);
    assign req_va  = grant_d ? dMissVAddr : iMissVAddr;
    assign pte_off = {{(PAGE_BITS-2){1'b0}}, req_va[ARCH_BITS-1:PAGE_BITS], 2'b00};
    assign tlb_ack = (sel == SEL_D) ? dTlbAck : iTlbAck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= SEL_I;
            last_grant <= SEL_D;
            vaddr      <= '0;
            addr       <= '0;
            pte        <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
            vaddr      <= vaddr_nxt;
            addr       <= addr_nxt;
            pte        <= pte_nxt;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        vaddr_nxt      = vaddr;
        addr_nxt       = addr;
        pte_nxt        = pte;
        cnt_nxt        = cnt;
        unique case (state)
            IDLE: begin
                if (iMissReq || dMissReq) begin
                    sel_nxt   = grant_d;
                    vaddr_nxt = req_va & PAGE_MASK;
                    addr_nxt  = ptbr + pte_off;
                    state_nxt = WALK;
                end
            end
            WALK: begin
                if (memAck) begin
                    pte_nxt   = memData;
                    state_nxt = memData[0] ? FILL : FAULT;
                end
            end
            FILL: begin
                if (tlb_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = RESP;
                end else if (cnt == CW'(FILL_TIMEOUT - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = FAULT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP, FAULT: begin
                last_grant_nxt = sel;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign memReq       = (state == WALK);
    assign memAddr      = addr;
    assign iTlbWriteReq = (state == FILL) && (sel == SEL_I);
    assign dTlbWriteReq = (state == FILL) && (sel == SEL_D);
    assign tlbVAddr     = vaddr;
    assign tlbPAddr     = pte & PAGE_MASK;
    assign iDone        = (state == RESP) && (sel == SEL_I);
    assign dDone        = (state == RESP) && (sel == SEL_D);
    assign iFault       = (state == FAULT) && (sel == SEL_I);
    assign dFault       = (state == FAULT) && (sel == SEL_D);

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl: walk, fault, arbitration,
// fill timeout, async reset and PTE-address wrap.
module tb_tlb_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ptbr;
    logic        iMissReq, dMissReq;
    logic [31:0] iMissVAddr, dMissVAddr;
    logic        iDone, dDone, iFault, dFault;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic        iTlbWriteReq, dTlbWriteReq;
    logic [31:0] tlbVAddr, tlbPAddr;
    logic        iTlbAck, dTlbAck;
    logic        busy;

    int total = 0;
    int bad   = 0;

    tlb_refill_ctrl #(
        .ARCH_BITS(32),
        .PAGE_BITS(12),
        .FILL_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ptbr(ptbr),
        .iMissReq(iMissReq),
        .iMissVAddr(iMissVAddr),
        .dMissReq(dMissReq),
        .dMissVAddr(dMissVAddr),
        .iDone(iDone),
        .dDone(dDone),
        .iFault(iFault),
        .dFault(dFault),
        .memReq(memReq),
        .memAddr(memAddr),
        .memAck(memAck),
        .memData(memData),
        .iTlbWriteReq(iTlbWriteReq),
        .dTlbWriteReq(dTlbWriteReq),
        .tlbVAddr(tlbVAddr),
        .tlbPAddr(tlbPAddr),
        .iTlbAck(iTlbAck),
        .dTlbAck(dTlbAck),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full successful walk of the side selected by d; request already granted next edge
    task automatic serve(input logic d, input logic [31:0] exp_addr,
                         input logic [31:0] exp_va, input logic [31:0] pte);
        step();
        chk("srv_memreq", {31'd0, memReq}, 32'd1);
        chk("srv_memaddr", memAddr, exp_addr);
        memAck  = 1'b1;
        memData = pte;
        step();
        memAck = 1'b0;
        chk("srv_istrobe", {31'd0, iTlbWriteReq}, {31'd0, !d});
        chk("srv_dstrobe", {31'd0, dTlbWriteReq}, {31'd0, d});
        chk("srv_tlbvaddr", tlbVAddr, exp_va);
        chk("srv_tlbpaddr", tlbPAddr, {pte[31:12], 12'h000});
        step();
        if (d) dTlbAck = 1'b1;
        else   iTlbAck = 1'b1;
        step();
        iTlbAck = 1'b0;
        dTlbAck = 1'b0;
        chk("srv_idone", {31'd0, iDone}, {31'd0, !d});
        chk("srv_ddone", {31'd0, dDone}, {31'd0, d});
        if (d) dMissReq = 1'b0;
        else   iMissReq = 1'b0;
        step();
        chk("srv_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int strobes;
        rst        = 1'b1;
        ptbr       = 32'h0;
        iMissReq   = 1'b0;
        dMissReq   = 1'b0;
        iMissVAddr = 32'h0;
        dMissVAddr = 32'h0;
        memAck     = 1'b0;
        memData    = 32'h0;
        iTlbAck    = 1'b0;
        dTlbAck    = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_memreq", {31'd0, memReq}, 32'd0);
        chk("rst_memaddr", memAddr, 32'h0);
        chk("rst_strobes", {30'd0, iTlbWriteReq, dTlbWriteReq}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single I miss: 0x1000 + 0x403*4 = 0x200C
        ptbr       = 32'h0000_1000;
        iMissVAddr = 32'h0040_3ABC;
        iMissReq   = 1'b1;
        step();
        chk("i_memreq", {31'd0, memReq}, 32'd1);
        chk("i_memaddr", memAddr, 32'h0000_200C);
        chk("i_busy", {31'd0, busy}, 32'd1);
        ptbr    = 32'hDEAD_0000;
        memAck  = 1'b1;
        memData = 32'h0007_7001;
        step();
        memAck = 1'b0;
        chk("i_memreq_drop", {31'd0, memReq}, 32'd0);
        chk("i_strobe", {30'd0, iTlbWriteReq, dTlbWriteReq}, 32'd2);
        chk("i_tlbvaddr", tlbVAddr, 32'h0040_3000);
        chk("i_tlbpaddr", tlbPAddr, 32'h0007_7000);
        step();
        chk("i_fill2_nodone", {31'd0, iDone}, 32'd0);
        iTlbAck = 1'b1;
        step();
        iTlbAck = 1'b0;
        chk("i_done", {30'd0, iDone, dDone}, 32'd2);
        chk("i_strobe_drop", {31'd0, iTlbWriteReq}, 32'd0);
        iMissReq = 1'b0;
        step();
        chk("i_done_pulse", {31'd0, iDone}, 32'd0);
        chk("i_idle", {31'd0, busy}, 32'd0);

        // Invalid PTE on a D miss: 0x1000 + 0x12345*4 = 0x49D14
        ptbr       = 32'h0000_1000;
        dMissVAddr = 32'h1234_5000;
        dMissReq   = 1'b1;
        step();
        chk("d_memaddr", memAddr, 32'h0004_9D14);
        memAck  = 1'b1;
        memData = 32'h0000_0000;
        step();
        memAck = 1'b0;
        chk("d_fault", {28'd0, iFault, dFault, iDone, dDone}, 32'b0100);
        chk("d_nostrobe", {30'd0, iTlbWriteReq, dTlbWriteReq}, 32'd0);
        dMissReq = 1'b0;
        step();
        chk("d_fault_pulse", {31'd0, dFault}, 32'd0);
        chk("d_idle", {31'd0, busy}, 32'd0);

        // Two simultaneous pairs: I first each time, then D
        iMissVAddr = 32'h0000_2123;
        dMissVAddr = 32'h0000_3456;
        iMissReq   = 1'b1;
        dMissReq   = 1'b1;
        serve(1'b0, 32'h0000_1008, 32'h0000_2000, 32'h0011_1001);
        serve(1'b1, 32'h0000_100C, 32'h0000_3000, 32'h0022_2001);
        iMissReq = 1'b1;
        dMissReq = 1'b1;
        serve(1'b0, 32'h0000_1008, 32'h0000_2000, 32'h0033_3001);
        serve(1'b1, 32'h0000_100C, 32'h0000_3000, 32'h0044_4001);

        // Fill timeout: ack never comes, 15 strobe cycles then iFault
        ptbr       = 32'h0;
        iMissVAddr = 32'h0000_1000;
        iMissReq   = 1'b1;
        step();
        memAck  = 1'b1;
        memData = 32'h0009_9001;
        step();
        memAck  = 1'b0;
        strobes = 0;
        for (int k = 0; k < 40 && iTlbWriteReq; k++) begin
            strobes++;
            step();
        end
        chk("to_strobe_cycles", strobes, 32'd15);
        chk("to_fault", {28'd0, iFault, dFault, iDone, dDone}, 32'b1000);
        chk("to_strobe_drop", {31'd0, iTlbWriteReq}, 32'd0);
        iMissReq = 1'b0;
        step();
        chk("to_idle", {31'd0, busy}, 32'd0);

        // Async reset mid-walk, then a late memAck is ignored
        ptbr       = 32'h0000_8000;
        iMissVAddr = 32'h0000_7000;
        iMissReq   = 1'b1;
        step();
        chk("ar_walk", {31'd0, memReq}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_memreq", {31'd0, memReq}, 32'd0);
        chk("ar_memaddr", memAddr, 32'h0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        rst      = 1'b0;
        iMissReq = 1'b0;
        memAck   = 1'b1;
        memData  = 32'h0055_5001;
        step();
        step();
        memAck = 1'b0;
        chk("ar_late_ack", {29'd0, busy, iTlbWriteReq, dTlbWriteReq}, 32'd0);

        // PTE address wrap: 0xFFFFFFF0 + 0x14 -> 0x4
        ptbr       = 32'hFFFF_FFF0;
        iMissVAddr = 32'h0000_5000;
        iMissReq   = 1'b1;
        step();
        chk("wrap_memaddr", memAddr, 32'h0000_0004);
        memAck  = 1'b1;
        memData = 32'h0;
        step();
        memAck   = 1'b0;
        iMissReq = 1'b0;
        chk("wrap_fault", {31'd0, iFault}, 32'd1);
        step();
        chk("wrap_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
